// File: rtl/isa_pkg.sv
// isa_pkg: RV32I opcode constants, instruction format enum and opcode-to-format mapping
package isa_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  function automatic fmt_e fmt_of(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_IMM || op == OP_JALR) ? FMT_I :
           (op == OP_STORE)                                 ? FMT_S :
           (op == OP_BRANCH)                                ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC)                 ? FMT_U :
           (op == OP_JAL)                                   ? FMT_J : FMT_R;
  endfunction
endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational field packer, {opcode, rd, rs1, rs2, funct3, funct7, imm} -> {inst, legal}
// imm follows the decoder convention (B and J hold offset>>1); legal=0 when imm cannot be represented.
module inst_pack
  import isa_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        legal
);
  fmt_e fmt;
  assign fmt = fmt_of(opcode);
  assign inst = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode}
              : fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
              : fmt == FMT_B ? {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}
              : fmt == FMT_U ? {imm[31:12], rd, opcode}
              : fmt == FMT_J ? {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode}
              : {funct7, rs2, rs1, funct3, rd, opcode};
  // B offsets are signed: the upper bits must be a pure sign extension of imm[11]
  assign legal = (fmt == FMT_I || fmt == FMT_S) ? imm[31:12] == '0
               : fmt == FMT_B ? (imm[31:11] == '0 || &imm[31:11])
               : fmt == FMT_U ? imm[11:0] == '0
               : fmt == FMT_J ? imm[31:20] == '0
               : 1'b1;
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs instruction fields into RV32I words, emitted with byte addresses through a 2-entry valid/ready FIFO
// Ports: clk/rst (async active-high), clear (sync), in_* request with in_ready,
// out_valid/out_ready/out_inst/out_addr, err pulse on rejected request, n_emit/n_err saturating counters.
module inst_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [CNT_W-1:0]  n_emit,
  output logic [CNT_W-1:0]  n_err
);
  logic [31:0]       inst;
  logic              legal;
  logic [31:0]       mem_inst [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_ctr;
  logic              acc, push, rej, pop;
  inst_pack u_pack (
    .opcode(in_opcode),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .funct3(in_funct3),
    .funct7(in_funct7),
    .imm(in_imm),
    .inst(inst),
    .legal(legal)
  );
  assign acc       = in_valid && in_ready;
  assign push      = acc && legal;
  assign rej       = acc && !legal;
  assign out_valid = cnt != 2'd0;
  assign pop       = out_valid && out_ready;
  assign cnt_nx    = cnt + {1'b0, push} - {1'b0, pop};
  assign out_inst  = mem_inst[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_inst[0] <= '0;
      mem_inst[1] <= '0;
      mem_addr[0] <= BASE_ADDR;
      mem_addr[1] <= BASE_ADDR;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt         <= 2'd0;
      in_ready    <= 1'b1;
      addr_ctr    <= BASE_ADDR;
      err         <= 1'b0;
      n_emit      <= '0;
      n_err       <= '0;
    end else if (clear) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      in_ready <= 1'b1;
      addr_ctr <= BASE_ADDR;
      err      <= 1'b0;
      n_emit   <= '0;
      n_err    <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= inst;
        mem_addr[wr_ptr] <= addr_ctr;
        wr_ptr           <= !wr_ptr;
        addr_ctr         <= addr_ctr + ADDR_W'(4);
      end
      if (pop) rd_ptr <= !rd_ptr;
      cnt      <= cnt_nx;
      // registered from the next occupancy so out_ready never reaches in_ready combinationally
      in_ready <= !cnt_nx[1];
      err      <= rej;
      n_emit   <= n_emit + CNT_W'(push && !(&n_emit));
      n_err    <= n_err + CNT_W'(rej && !(&n_err));
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and random-legal checks of inst_encoder with a 4-bit address space
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [3:0]  out_addr;
  logic        err;
  logic [15:0] n_emit, n_err;
  int npass = 0, ntot = 0;

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .n_emit(n_emit), .n_err(n_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // 0=R 1=I 2=S 3=B 4=U 5=J
  function automatic int fmt_tb(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 1;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b0110111, 7'b0010111: return 4;
      7'b1101111: return 5;
      default: return 0;
    endcase
  endfunction

  // Reference decoder: {op, rd, rs1, rs2, f3, f7, imm}, fields unused by the format read as zero
  function automatic logic [63:0] dec(input logic [31:0] ir);
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; imm = 0;
    case (fmt_tb(ir[6:0]))
      1: begin imm = {20'b0, ir[31:20]}; rs1 = ir[19:15]; f3 = ir[14:12]; rd = ir[11:7]; end
      2: begin imm = {20'b0, ir[31:25], ir[11:7]}; rs2 = ir[24:20]; rs1 = ir[19:15]; f3 = ir[14:12]; end
      3: begin imm = {{20{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8]}; rs2 = ir[24:20]; rs1 = ir[19:15]; f3 = ir[14:12]; end
      4: begin imm = {ir[31:12], 12'b0}; rd = ir[11:7]; end
      5: begin imm = {12'b0, ir[31], ir[19:12], ir[20], ir[30:21]}; rd = ir[11:7]; end
      default: begin f7 = ir[31:25]; rs2 = ir[24:20]; rs1 = ir[19:15]; f3 = ir[14:12]; rd = ir[11:7]; end
    endcase
    return {ir[6:0], rd, rs1, rs2, f3, f7, imm};
  endfunction

  initial begin
    logic [6:0] ops [9];
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
    tick; tick;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_n_emit", 64'(n_emit), 64'd0);
    chk("rst_n_err", 64'(n_err), 64'd0);

    set_req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h7FF);
    tick; in_valid = 1'b0;
    chk("i_valid", 64'(out_valid), 64'd1);
    chk("i_inst", 64'(out_inst), 64'h7FF10093);
    chk("i_addr", 64'(out_addr), 64'd0);
    chk("i_n_emit", 64'(n_emit), 64'd1);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("i_popped", 64'(out_valid), 64'd0);

    set_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFE);
    tick; in_valid = 1'b0;
    chk("b_inst", 64'(out_inst), 64'hFE208EE3);
    chk("b_addr", 64'(out_addr), 64'd4);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    set_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    tick; in_valid = 1'b0;
    chk("bad_u_err", 64'(err), 64'd1);
    chk("bad_u_n_err", 64'(n_err), 64'd1);
    chk("bad_u_valid", 64'(out_valid), 64'd0);
    chk("bad_u_n_emit", 64'(n_emit), 64'd2);
    tick;
    chk("err_pulse_end", 64'(err), 64'd0);
    set_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick; in_valid = 1'b0;
    chk("u_inst", 64'(out_inst), 64'h123452B7);
    chk("u_addr_unmoved", 64'(out_addr), 64'd8);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    clear = 1'b1; tick; clear = 1'b0;
    chk("clr_n_emit", 64'(n_emit), 64'd0);
    chk("clr_n_err", 64'(n_err), 64'd0);
    set_req(7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    tick;
    chk("bp_ready1", 64'(in_ready), 64'd1);
    set_req(7'b0110011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    tick;
    chk("bp_full", 64'(in_ready), 64'd0);
    set_req(7'b0110011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    tick;
    chk("bp_no_accept", 64'(n_emit), 64'd2);
    chk("bp_stable_inst", 64'(out_inst), 64'h000000B3);
    chk("bp_stable_addr", 64'(out_addr), 64'd0);
    out_ready = 1'b1; tick;
    chk("bp_w1_inst", 64'(out_inst), 64'h00000133);
    chk("bp_w1_addr", 64'(out_addr), 64'd4);
    chk("bp_reopen", 64'(in_ready), 64'd1);
    tick; in_valid = 1'b0;
    chk("bp_w2_inst", 64'(out_inst), 64'h000001B3);
    chk("bp_w2_addr", 64'(out_addr), 64'd8);
    chk("bp_w2_valid", 64'(out_valid), 64'd1);
    tick; out_ready = 1'b0;
    chk("bp_drained", 64'(out_valid), 64'd0);

    set_req(7'b0110011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    tick; tick; in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_addr", 64'(out_addr), 64'd0);
    chk("arst_n_emit", 64'(n_emit), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick; rst = 1'b0;

    set_req(7'b0110011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    clear = 1'b1; tick; clear = 1'b0; in_valid = 1'b0;
    chk("clr_wins_valid", 64'(out_valid), 64'd0);
    chk("clr_wins_n_emit", 64'(n_emit), 64'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] imm, r;
      op = ops[$urandom_range(0, 8)];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom); r = $urandom; imm = 0;
      case (fmt_tb(op))
        1: begin imm = r & 32'hFFF; rs2 = 0; f7 = 0; end
        2: begin imm = r & 32'hFFF; rd = 0; f7 = 0; end
        3: begin imm = {{20{r[11]}}, r[11:0]}; rd = 0; f7 = 0; end
        4: begin imm = r & 32'hFFFFF000; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; end
        5: begin imm = r & 32'hFFFFF; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; end
        default: imm = 0;
      endcase
      set_req(op, rd, rs1, rs2, f3, f7, (fmt_tb(op) == 0) ? r : imm);
      tick;
      in_valid = 1'b0;
      chk("rt_fields", dec(out_inst), {op, rd, rs1, rs2, f3, f7, imm});
      chk("rt_addr", 64'({out_valid, out_addr}), 64'({1'b1, 4'(i * 4)}));
    end
    tick;
    out_ready = 1'b0;
    chk("rt_n_emit", 64'(n_emit), 64'd300);
    chk("rt_n_err", 64'(n_err), 64'd0);
    chk("rt_drained", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
